// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB slave between NUM_REQ requesters.
// Runs SETUP/ACCESS, returns rdata/err, aborts hung accesses after TIMEOUT.
module apb_req_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst_b,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pready,
  input  logic                      pslverr
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       last_gnt_q, last_gnt_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic                arb_hit;
  logic [IW-1:0]       arb_idx;
  logic                xfer_done;
  logic                tmo;
  logic                arb_en;
  logic                accept;

  // Walk from furthest to nearest so the nearest hit after last_gnt wins.
  always_comb begin : arb
    int            idx;
    logic [IW-1:0] ix;
    idx     = 0;
    ix      = '0;
    arb_hit = 1'b0;
    arb_idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_gnt_q) + k) % NUM_REQ;
      ix  = IW'(idx);
      if (req_valid[ix]) begin
        arb_hit = 1'b1;
        arb_idx = ix;
      end
    end
  end

  assign xfer_done = (state_q == ACCESS) && pready;
  assign tmo       = (state_q == ACCESS) && !pready &&
                     (tcnt_q == TW'(TIMEOUT - 1));
  assign arb_en    = rst_b &&
                     ((state_q == IDLE) || xfer_done || tmo);
  assign accept    = arb_en && arb_hit;
  assign req_ready = accept ? (NUM_REQ'(1) << arb_idx) : '0;

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    tcnt_d      = tcnt_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        tcnt_d    = '0;
      end
      ACCESS: begin
        if (xfer_done || tmo) begin
          rsp_valid_d = NUM_REQ'(1) << last_gnt_q;
          rsp_err_d   = xfer_done ? pslverr : 1'b1;
          if (xfer_done && !pwrite_q) begin
            rsp_rdata_d = prdata;
          end
          state_d   = IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A grant overrides the IDLE return of a completing access.
    if (accept) begin
      state_d    = SETUP;
      psel_d     = 1'b1;
      penable_d  = 1'b0;
      last_gnt_d = arb_idx;
      pwrite_d   = req_write[arb_idx];
      paddr_d    = req_addr[arb_idx*ADDR_W +: ADDR_W];
      pwdata_d   = req_wdata[arb_idx*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= IDLE;
      last_gnt_q  <= IW'(NUM_REQ - 1);
      tcnt_q      <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      tcnt_q      <= tcnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with a small APB slave model.
// Unwritten slave words read back as {20'hABCDE, paddr}.
module tb_apb_req_arbiter;

  localparam int NR = 2;
  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk;
  logic          rst_b;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_ready;
  logic [NR-1:0] req_write;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0] rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  int checks;
  int failures;

  bit [31:0] mem [1024];
  bit        wflag [1024];

  apb_req_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_b(rst_b),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (psel && penable && pready && pwrite) begin
      mem[paddr[11:2]]   <= pwdata;
      wflag[paddr[11:2]] <= 1'b1;
    end
  end

  assign prdata = wflag[paddr[11:2]] ? mem[paddr[11:2]]
                                     : {20'hABCDE, paddr};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input logic w,
                         input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_valid[r]            = 1'b1;
    req_write[r]            = w;
    req_addr[r*AW +: AW]    = a;
    req_wdata[r*DW +: DW]   = d;
  endtask

  task automatic clr_req();
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_g;
    int prev_g;
    checks   = 0;
    failures = 0;
    rst_b    = 1'b0;
    pready   = 1'b1;
    pslverr  = 1'b0;
    clr_req();

    // Reset state
    tick();
    req_valid = 2'b11;
    #1;
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_psel", 64'(psel), 64'(0));
    chk("rst_penable", 64'(penable), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_paddr", 64'(paddr), 64'(0));
    clr_req();
    rst_b = 1'b1;
    tick();

    // Single write then read, requester 0
    set_req(0, 1'b1, 12'h004, 32'hDEADBEEF);
    #1;
    chk("wr_ready", 64'(req_ready), 64'(1));
    tick();
    clr_req();
    #1;
    chk("wr_setup_psel", 64'(psel), 64'(1));
    chk("wr_setup_pen", 64'(penable), 64'(0));
    chk("wr_paddr", 64'(paddr), 64'(12'h004));
    chk("wr_pwrite", 64'(pwrite), 64'(1));
    chk("wr_pwdata", 64'(pwdata), 64'(32'hDEADBEEF));
    tick();
    #1;
    chk("wr_access_pen", 64'(penable), 64'(1));
    chk("wr_access_rsp", 64'(rsp_valid), 64'(0));
    tick();
    #1;
    chk("wr_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("wr_rsp_err", 64'(rsp_err), 64'(0));
    chk("wr_rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("wr_idle_psel", 64'(psel), 64'(0));
    set_req(0, 1'b0, 12'h004, 32'h0);
    #1;
    chk("rd_ready", 64'(req_ready), 64'(1));
    tick();
    clr_req();
    #1;
    chk("rd_pwrite", 64'(pwrite), 64'(0));
    tick();
    tick();
    #1;
    chk("rd_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("rd_rsp_rdata", 64'(rsp_rdata), 64'(32'hDEADBEEF));
    chk("rd_rsp_err", 64'(rsp_err), 64'(0));

    // Simultaneous requests right after reset
    rst_b = 1'b0;
    tick();
    rst_b = 1'b1;
    set_req(0, 1'b0, 12'h000, 32'h0);
    set_req(1, 1'b0, 12'h400, 32'h0);
    #1;
    chk("sim_ready0", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid[0] = 1'b0;
    #1;
    chk("sim_setup_ready", 64'(req_ready), 64'(0));
    chk("sim_paddr0", 64'(paddr), 64'(12'h000));
    tick();
    #1;
    chk("sim_ready1", 64'(req_ready), 64'(2'b10));
    tick();
    clr_req();
    #1;
    chk("sim_rsp0", 64'(rsp_valid), 64'(2'b01));
    chk("sim_rdata0", 64'(rsp_rdata), 64'(32'hABCDE000));
    chk("sim_psel_cont", 64'(psel), 64'(1));
    chk("sim_pen_drop", 64'(penable), 64'(0));
    chk("sim_paddr1", 64'(paddr), 64'(12'h400));
    tick();
    #1;
    chk("sim_access1", 64'(rsp_valid), 64'(0));
    tick();
    #1;
    chk("sim_rsp1", 64'(rsp_valid), 64'(2'b10));
    chk("sim_rdata1", 64'(rsp_rdata), 64'(32'hABCDE400));
    chk("sim_idle_psel", 64'(psel), 64'(0));

    // Fairness: both continuously valid, 8 transfers
    set_req(0, 1'b0, 12'h100, 32'h0);
    set_req(1, 1'b0, 12'h200, 32'h0);
    exp_g  = 0;
    prev_g = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("fair_grant", 64'(req_ready), 64'(1 << exp_g));
      if (i > 0) begin
        chk("fair_psel", 64'(psel), 64'(1));
        chk("fair_no_rsp", 64'(rsp_valid), 64'(0));
      end
      tick();
      if (i == 7) clr_req();
      #1;
      chk("fair_setup_ready", 64'(req_ready), 64'(0));
      if (i > 0) begin
        chk("fair_rsp", 64'(rsp_valid), 64'(1 << prev_g));
      end
      tick();
      prev_g = exp_g;
      exp_g  = exp_g ^ 1;
    end
    #1;
    chk("fair_last_ready", 64'(req_ready), 64'(0));
    tick();
    #1;
    chk("fair_last_rsp", 64'(rsp_valid), 64'(2'b10));
    chk("fair_idle_psel", 64'(psel), 64'(0));

    // Slave error on requester 1
    set_req(1, 1'b0, 12'h800, 32'h0);
    #1;
    chk("err_ready", 64'(req_ready), 64'(2'b10));
    tick();
    clr_req();
    tick();
    pslverr = 1'b1;
    tick();
    pslverr = 1'b0;
    #1;
    chk("err_rsp_valid", 64'(rsp_valid), 64'(2'b10));
    chk("err_rsp_err", 64'(rsp_err), 64'(1));
    chk("err_rdata", 64'(rsp_rdata), 64'(32'hABCDE800));

    // Timeout: pready low for 20 cycles
    pready = 1'b0;
    set_req(0, 1'b0, 12'h010, 32'h0);
    #1;
    chk("tmo_ready", 64'(req_ready), 64'(1));
    tick();
    clr_req();
    tick();
    for (int k = 1; k <= 16; k++) begin
      #1;
      chk("tmo_pen", 64'(penable), 64'(1));
      chk("tmo_no_rsp", 64'(rsp_valid), 64'(0));
      tick();
    end
    #1;
    chk("tmo_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("tmo_rsp_err", 64'(rsp_err), 64'(1));
    chk("tmo_rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("tmo_psel", 64'(psel), 64'(0));
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      chk("tmo_after_psel", 64'(psel), 64'(0));
      chk("tmo_after_rsp", 64'(rsp_valid), 64'(0));
    end

    // pready on exactly the 16th ACCESS cycle
    set_req(0, 1'b0, 12'h020, 32'h0);
    #1;
    chk("tmo2_ready", 64'(req_ready), 64'(1));
    tick();
    clr_req();
    tick();
    for (int k = 1; k <= 16; k++) begin
      if (k == 16) pready = 1'b1;
      #1;
      chk("tmo2_no_rsp", 64'(rsp_valid), 64'(0));
      tick();
    end
    pready = 1'b0;
    #1;
    chk("tmo2_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("tmo2_rsp_err", 64'(rsp_err), 64'(0));
    chk("tmo2_rdata", 64'(rsp_rdata), 64'(32'hABCDE020));

    // Reset during ACCESS with pready low
    set_req(1, 1'b0, 12'h030, 32'h0);
    tick();
    clr_req();
    tick();
    tick();
    #1;
    chk("mid_pen_before", 64'(penable), 64'(1));
    rst_b = 1'b0;
    #1;
    chk("mid_psel", 64'(psel), 64'(0));
    chk("mid_pen", 64'(penable), 64'(0));
    chk("mid_rsp", 64'(rsp_valid), 64'(0));
    chk("mid_paddr", 64'(paddr), 64'(0));
    tick();
    rst_b  = 1'b1;
    pready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      chk("mid_no_rsp", 64'(rsp_valid), 64'(0));
      chk("mid_no_psel", 64'(psel), 64'(0));
    end

    // Only requester 1 valid after reset
    set_req(1, 1'b0, 12'h030, 32'h0);
    #1;
    chk("post_ready1", 64'(req_ready), 64'(2'b10));
    tick();
    clr_req();
    #1;
    chk("post_paddr1", 64'(paddr), 64'(12'h030));
    tick();
    tick();
    #1;
    chk("post_rsp1", 64'(rsp_valid), 64'(2'b10));
    chk("post_rdata1", 64'(rsp_rdata), 64'(32'hABCDE030));

    // Both valid after reset: requester 0 first
    rst_b = 1'b0;
    tick();
    rst_b = 1'b1;
    set_req(0, 1'b0, 12'h040, 32'h0);
    set_req(1, 1'b0, 12'h050, 32'h0);
    #1;
    chk("post_both_ready", 64'(req_ready), 64'(2'b01));
    tick();
    clr_req();
    tick();
    tick();
    #1;
    chk("post_both_rsp", 64'(rsp_valid), 64'(2'b01));
    chk("post_both_rdata", 64'(rsp_rdata), 64'(32'hABCDE040));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
